// File: rtl/fir_mac_engine.sv
// Self-sequenced FIR core: fetches samples/coefficients from 1-cycle-latency RAMs, runs one MAC
// per tap over a runtime tap count, then rounds/saturates and offers the result over valid/ready.
module fir_mac_engine #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned MAX_TAPS   = 32,
  parameter int unsigned GUARD      = 4,
  parameter int unsigned SMP_ADDR_W = 13,
  parameter int unsigned ROUND_EN   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [$clog2(MAX_TAPS):0]     cfg_taps,
  input  logic [SMP_ADDR_W:0]           cfg_samples,
  output logic [$clog2(MAX_TAPS)-1:0]   coef_addr,
  input  logic [COEF_WIDTH-1:0]         coef_data,
  output logic [SMP_ADDR_W-1:0]         smp_addr,
  input  logic [DATA_WIDTH-1:0]         smp_data,
  output logic [OUT_WIDTH-1:0]          y_data,
  output logic [SMP_ADDR_W-1:0]         y_idx,
  output logic                          y_valid,
  input  logic                          y_ready,
  output logic                          sat_flag,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned TAP_W = $clog2(MAX_TAPS);
  localparam int unsigned TW    = TAP_W + 1;
  localparam int unsigned NW    = SMP_ADDR_W + 1;
  localparam int unsigned PW    = DATA_WIDTH + COEF_WIDTH;
  localparam int unsigned ACC_W = PW + GUARD;
  localparam int          SH    = int'(PW) - 1 - int'(OUT_WIDTH);

  localparam logic signed [ACC_W-1:0] RND =
      (ROUND_EN != 0 && SH > 0) ? (ACC_W'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;
  localparam logic signed [ACC_W-1:0] YMAX = (ACC_W'(1) << (OUT_WIDTH - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] YMIN = ~YMAX;

  typedef enum logic [2:0] {StIdle, StFetch, StShift, StMac, StDrain, StOut, StFin} state_e;

  state_e                         state_q, state_d;
  logic [TW-1:0]                  taps_q, taps_d, taps_clamp;
  logic [NW-1:0]                  nsmp_q, nsmp_d, n_q, n_d, n_inc;
  logic [TAP_W-1:0]               k_q, k_d;
  logic signed [DATA_WIDTH-1:0]   x_q [MAX_TAPS];
  logic signed [DATA_WIDTH-1:0]   x_d [MAX_TAPS];
  logic signed [DATA_WIDTH-1:0]   xk_q, xk_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d, acc_fin, rnd_sum, shifted;
  logic signed [PW-1:0]           prod;
  logic [OUT_WIDTH-1:0]           y_q, y_d;
  logic                           sat_q, sat_d;

  // Full-precision product; coef_data lines up with xk_q one cycle after coef_addr = k.
  assign prod    = $signed(coef_data) * xk_q;
  assign acc_fin = acc_q + {{GUARD{prod[PW-1]}}, prod};
  assign rnd_sum = acc_fin + RND;
  assign shifted = rnd_sum >>> SH;
  assign n_inc   = n_q + NW'(1);

  always_comb begin
    taps_clamp = cfg_taps;
    if (cfg_taps == '0) begin
      taps_clamp = TW'(1);
    end else if (cfg_taps > TW'(MAX_TAPS)) begin
      taps_clamp = TW'(MAX_TAPS);
    end
  end

  always_comb begin
    state_d = state_q;
    taps_d  = taps_q;
    nsmp_d  = nsmp_q;
    n_d     = n_q;
    k_d     = k_q;
    x_d     = x_q;
    xk_d    = xk_q;
    acc_d   = acc_q;
    y_d     = y_q;
    sat_d   = sat_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            taps_d = taps_clamp;
            nsmp_d = cfg_samples;
            n_d    = '0;
            sat_d  = 1'b0;
            for (int i = 0; i < int'(MAX_TAPS); i++) x_d[i] = '0;
            state_d = (cfg_samples == '0) ? StFin : StFetch;
          end
        end
        StFetch: state_d = StShift;
        StShift: begin
          x_d[0] = smp_data;
          for (int i = 1; i < int'(MAX_TAPS); i++) x_d[i] = x_q[i-1];
          acc_d   = '0;
          k_d     = '0;
          state_d = StMac;
        end
        StMac: begin
          xk_d = x_q[k_q];
          if (k_q != '0) acc_d = acc_fin;
          if ({1'b0, k_q} == taps_q - TW'(1)) begin
            state_d = StDrain;
          end else begin
            k_d = k_q + TAP_W'(1);
          end
        end
        StDrain: begin
          acc_d = acc_fin;
          if (shifted > YMAX) begin
            y_d   = YMAX[OUT_WIDTH-1:0];
            sat_d = 1'b1;
          end else if (shifted < YMIN) begin
            y_d   = YMIN[OUT_WIDTH-1:0];
            sat_d = 1'b1;
          end else begin
            y_d = shifted[OUT_WIDTH-1:0];
          end
          state_d = StOut;
        end
        StOut: begin
          if (y_ready) begin
            n_d     = n_inc;
            state_d = (n_inc == nsmp_q) ? StFin : StFetch;
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      taps_q  <= '0;
      nsmp_q  <= '0;
      n_q     <= '0;
      k_q     <= '0;
      for (int i = 0; i < int'(MAX_TAPS); i++) x_q[i] <= '0;
      xk_q    <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      taps_q  <= taps_d;
      nsmp_q  <= nsmp_d;
      n_q     <= n_d;
      k_q     <= k_d;
      x_q     <= x_d;
      xk_q    <= xk_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
    end
  end

  assign coef_addr = k_q;
  assign smp_addr  = n_q[SMP_ADDR_W-1:0];
  assign y_idx     = n_q[SMP_ADDR_W-1:0];
  assign y_data    = y_q;
  assign y_valid   = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);
  assign sat_flag  = sat_q;

endmodule
